// File: rtl/seq_signed_mult.sv
// Iterative shift-add multiplier (signed/unsigned) with start/busy/done handshake and flush.
// One partial-product step per RUN cycle; the sign is applied once in FIX.
module seq_signed_mult #(
   parameter int WL = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_signed,
   input  logic [WL-1:0]   a,
   input  logic [WL-1:0]   b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [2*WL-1:0] prod,
   output logic [WL-1:0]   hi,
   output logic [WL-1:0]   lo
);

   localparam int CW = $clog2(WL);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t            state, state_nxt;
   logic [2*WL-1:0]   mcand;
   logic [2*WL-1:0]   acc;
   logic [WL-1:0]     mplier;
   logic [CW-1:0]     count;
   logic              sign;
   logic [WL-1:0]     mag_a, mag_b;

   // Magnitude stays WL bits wide so -2^(WL-1) maps to the unsigned value 2^(WL-1).
   assign mag_a = (is_signed && a[WL-1]) ? (~a + WL'(1)) : a;
   assign mag_b = (is_signed && b[WL-1]) ? (~b + WL'(1)) : b;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (flush) state_nxt = IDLE;
                  else if (count == CW'(WL-1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         count  <= '0;
         sign   <= 1'b0;
         prod   <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == FIX) && !flush;
         case (state)
            IDLE: if (start) begin
               mcand  <= {{WL{1'b0}}, mag_a};
               mplier <= mag_b;
               acc    <= '0;
               count  <= '0;
               sign   <= is_signed & (a[WL-1] ^ b[WL-1]);
            end
            RUN: if (!flush) begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + CW'(1);
            end
            FIX: if (!flush) prod <= sign ? (~acc + (2*WL)'(1)) : acc;
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign hi   = prod[2*WL-1:WL];
   assign lo   = prod[WL-1:0];

endmodule

// File: tb/tb_seq_signed_mult.sv
// Directed and randomised checks of seq_signed_mult at WL=8, plus one WL=32 corner.
module tb_seq_signed_mult;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, sgn8, flush8;
   logic [7:0]  a8, b8;
   logic        busy8, done8;
   logic [15:0] prod8;
   logic [7:0]  hi8, lo8;
   logic        start32, sgn32, flush32;
   logic [31:0] a32, b32;
   logic        busy32, done32;
   logic [63:0] prod32;
   logic [31:0] hi32, lo32;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_signed_mult #(.WL(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8), .a(a8), .b(b8),
      .flush(flush8), .busy(busy8), .done(done8), .prod(prod8), .hi(hi8), .lo(lo8)
   );

   seq_signed_mult #(.WL(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .is_signed(sgn32), .a(a32), .b(b32),
      .flush(flush32), .busy(busy32), .done(done32), .prod(prod32), .hi(hi32), .lo(lo32)
   );

   // Issue one WL=8 op and observe 14 cycles. j counts edges after the accept edge;
   // poke/flush/rst are driven at observation j and sampled at edge j+1.
   task automatic op8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                      input int poke_j, input int flush_j, input int rst_j, input logic fs,
                      output logic [15:0] p, output int lat, output int ndone,
                      output logic [31:0] bh);
      @(negedge clk);
      start8 = 1'b1; sgn8 = s; a8 = av; b8 = bv; flush8 = fs;
      @(negedge clk);
      start8 = 1'b0; flush8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      lat = -1; ndone = 0; bh = '0; p = '0;
      for (int j = 0; j < 14; j++) begin
         if (j > 0) @(negedge clk);
         bh[j] = busy8;
         if (done8) begin
            ndone++;
            if (lat < 0) lat = j;
         end
         start8 = (j == poke_j);
         if (j == poke_j) begin a8 = 8'h11; b8 = 8'h11; sgn8 = ~s; end
         flush8 = (j == flush_j);
         rst    = (j == rst_j);
      end
      start8 = 1'b0; flush8 = 1'b0; rst = 1'b0;
      p = prod8;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (prod8 !== 16'h0) begin fails++; $display("FAIL reset_prod: got %h want 0000", prod8); end
      tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy8); end
      tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done8); end
      tests++; if (prod32 !== 64'h0) begin fails++; $display("FAIL reset_prod32: got %h want 0", prod32); end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [15:0] p; int lat, nd; logic [31:0] bh;
      op8(1'b1, 8'hFD, 8'h05, 99, 99, 99, 1'b0, p, lat, nd, bh);
      tests++; if (p !== 16'hFFF1) begin fails++; $display("FAIL signed_m3x5: got %h want fff1", p); end
      tests++; if (lat !== 9) begin fails++; $display("FAIL signed_latency: got %0d want 9", lat); end
      tests++; if (bh !== 32'h1FF) begin fails++; $display("FAIL signed_busy: got %h want 000001ff", bh); end
      tests++; if (nd !== 1) begin fails++; $display("FAIL signed_done_count: got %0d want 1", nd); end
      tests++; if (hi8 !== 8'hFF || lo8 !== 8'hF1) begin fails++; $display("FAIL signed_hilo: got %h %h want ff f1", hi8, lo8); end
      op8(1'b0, 8'hFD, 8'h05, 99, 99, 99, 1'b0, p, lat, nd, bh);
      tests++; if (p !== 16'h04F1) begin fails++; $display("FAIL unsigned_fdx05: got %h want 04f1", p); end
      tests++; if (hi8 !== 8'h04) begin fails++; $display("FAIL unsigned_hi: got %h want 04", hi8); end
   endtask

   task automatic test_corners;
      logic [15:0] p; int lat, nd; logic [31:0] bh; int j;
      op8(1'b1, 8'h80, 8'h80, 99, 99, 99, 1'b0, p, lat, nd, bh);
      tests++; if (p !== 16'h4000) begin fails++; $display("FAIL min_x_min: got %h want 4000", p); end
      op8(1'b1, 8'h80, 8'h7F, 99, 99, 99, 1'b0, p, lat, nd, bh);
      tests++; if (p !== 16'hC080) begin fails++; $display("FAIL min_x_max: got %h want c080", p); end
      op8(1'b0, 8'hFF, 8'hFF, 99, 99, 99, 1'b0, p, lat, nd, bh);
      tests++; if (p !== 16'hFE01) begin fails++; $display("FAIL ff_x_ff: got %h want fe01", p); end
      op8(1'b1, 8'h00, 8'h55, 99, 99, 99, 1'b0, p, lat, nd, bh);
      tests++; if (p !== 16'h0000) begin fails++; $display("FAIL zero_op: got %h want 0000", p); end
      tests++; if (lat !== 9) begin fails++; $display("FAIL zero_latency: got %0d want 9", lat); end
      @(negedge clk);
      start32 = 1'b1; sgn32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h2;
      @(negedge clk);
      start32 = 1'b0; a32 = '0; b32 = '0;
      j = 0;
      while (!done32 && j < 60) begin @(negedge clk); j++; end
      tests++; if (j !== 33) begin fails++; $display("FAIL wl32_latency: got %0d want 33", j); end
      tests++; if (hi32 !== 32'hFFFF_FFFF || lo32 !== 32'hFFFF_FFFE) begin
         fails++; $display("FAIL wl32_m1x2: got %h %h want ffffffff fffffffe", hi32, lo32);
      end
   endtask

   task automatic test_control;
      logic [15:0] p; int lat, nd; logic [31:0] bh;
      op8(1'b1, 8'h07, 8'h06, 3, 99, 99, 1'b0, p, lat, nd, bh);
      tests++; if (p !== 16'h002A || lat !== 9 || nd !== 1) begin
         fails++; $display("FAIL start_mid_run: got %h lat %0d n %0d want 002a lat 9 n 1", p, lat, nd);
      end
      tests++; if (bh !== 32'h1FF) begin fails++; $display("FAIL start_mid_run_busy: got %h want 000001ff", bh); end
      op8(1'b1, 8'h09, 8'h09, 99, 3, 99, 1'b0, p, lat, nd, bh);
      tests++; if (nd !== 0) begin fails++; $display("FAIL flush_no_done: got %0d want 0", nd); end
      tests++; if (bh !== 32'hF) begin fails++; $display("FAIL flush_busy: got %h want 0000000f", bh); end
      tests++; if (p !== 16'h002A) begin fails++; $display("FAIL flush_prod_held: got %h want 002a", p); end
      @(negedge clk); flush8 = 1'b1;
      @(negedge clk); flush8 = 1'b0;
      tests++; if (busy8 !== 1'b0 || prod8 !== 16'h002A) begin
         fails++; $display("FAIL idle_flush: busy %b prod %h want 0 002a", busy8, prod8);
      end
      op8(1'b0, 8'h02, 8'h03, 99, 99, 99, 1'b1, p, lat, nd, bh);
      tests++; if (p !== 16'h0006 || lat !== 9) begin
         fails++; $display("FAIL flush_with_start: got %h lat %0d want 0006 lat 9", p, lat);
      end
      op8(1'b1, 8'h09, 8'h09, 99, 99, 2, 1'b0, p, lat, nd, bh);
      tests++; if (p !== 16'h0000 || nd !== 0) begin
         fails++; $display("FAIL rst_mid_op: got %h n %0d want 0000 n 0", p, nd);
      end
      tests++; if (bh !== 32'h7) begin fails++; $display("FAIL rst_mid_busy: got %h want 00000007", bh); end
   endtask

   task automatic test_back_to_back;
      int j1, j2; logic [15:0] p1;
      @(negedge clk);
      start8 = 1'b1; sgn8 = 1'b1; a8 = 8'hFD; b8 = 8'h05;
      @(negedge clk);
      start8 = 1'b0;
      j1 = 0;
      while (!done8 && j1 < 20) begin @(negedge clk); j1++; end
      p1 = prod8;
      start8 = 1'b1; sgn8 = 1'b0; a8 = 8'hFF; b8 = 8'h02;
      @(negedge clk);
      start8 = 1'b0;
      j2 = 1;
      while (!done8 && j2 < 25) begin @(negedge clk); j2++; end
      tests++; if (j1 !== 9 || p1 !== 16'hFFF1) begin
         fails++; $display("FAIL b2b_first: got lat %0d %h want 9 fff1", j1, p1);
      end
      tests++; if (j2 !== 10 || prod8 !== 16'h01FE) begin
         fails++; $display("FAIL b2b_second: got gap %0d %h want 10 01fe", j2, prod8);
      end
   endtask

   task automatic test_random;
      logic [15:0] p, exp_p; int lat, nd; logic [31:0] bh;
      logic s; logic [7:0] av, bv; longint x, y;
      for (int i = 0; i < 1000; i++) begin
         s  = 1'($urandom_range(0, 1));
         av = 8'($urandom_range(0, 255));
         bv = 8'($urandom_range(0, 255));
         x  = s ? longint'($signed(av)) : longint'(av);
         y  = s ? longint'($signed(bv)) : longint'(bv);
         exp_p = 16'(x * y);
         op8(s, av, bv, 99, 99, 99, 1'b0, p, lat, nd, bh);
         tests++;
         if (p !== exp_p || lat !== 9) begin
            fails++;
            $display("FAIL random_%0d: s=%b a=%h b=%h got %h lat %0d want %h lat 9", i, s, av, bv, p, lat, exp_p);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start8 = 1'b0; sgn8 = 1'b0; flush8 = 1'b0; a8 = '0; b8 = '0;
      start32 = 1'b0; sgn32 = 1'b0; flush32 = 1'b0; a32 = '0; b32 = '0;
      test_reset;
      test_basic;
      test_corners;
      test_control;
      test_back_to_back;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
